// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths, command encodings and arbiter state encoding
// for the SDRAM command arbiter slice.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_BA_W   = 2;
    localparam int SDRAM_DQ_W   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_MRS       = 4'b0000;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_NOP       = 4'b0111;

    // Bit positions inside the one-hot grant / ack vectors
    localparam int GNT_REF = 0;
    localparam int GNT_WR  = 1;
    localparam int GNT_RD  = 2;

    // last_rw flag values; reset value means "read served last" so the
    // first write/read tie goes to the writer
    localparam logic LAST_RD = 1'b0;
    localparam logic LAST_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_ARBIT   = 3'd1,
        ST_REFRESH = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: engine request/grant handshakes, engine command buses
// and the SDRAM pin-side outputs. slave = arbiter side, master = engine side.
interface sdram_arbiter_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int BA_W   = SDRAM_BA_W,
    parameter int DQ_W   = SDRAM_DQ_W
) ();
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;

    logic              refresh_req;
    logic              refresh_ack;
    logic              refresh_end;
    logic [3:0]        refresh_cmd;

    logic              wr_req;
    logic              wr_ack;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic [DQ_W-1:0]   wr_dq;
    logic              wr_dq_oe;

    logic              rd_req;
    logic              rd_ack;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;

    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  refresh_req, refresh_end, refresh_cmd,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq, wr_dq_oe,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output refresh_ack, wr_ack, rd_ack,
        output sdram_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output refresh_req, refresh_end, refresh_cmd,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_dq, wr_dq_oe,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  refresh_ack, wr_ack, rd_ack,
        input  sdram_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbit_grant.sv
// sdram_arbit_grant: combinational chooser turning engine requests into a
// one-hot next grant. Refresh always wins. Optional write/read fairness is
// enabled with the SDRAM_ARBIT_FAIRNESS_EN macro.
module sdram_arbit_grant
    import sdram_pkg::*;
(
    input  logic       refresh_req,
    input  logic       wr_req,
    input  logic       rd_req,
`ifdef SDRAM_ARBIT_FAIRNESS_EN
    input  logic       last_rw,
`endif
    output logic [2:0] grant
);

    // Priority pick; a write/read tie is the only place fairness matters
    always_comb begin
        grant = '0;
        if (refresh_req) begin
            grant[GNT_REF] = 1'b1;
        end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_FAIRNESS_EN
            if (last_rw == LAST_WR) grant[GNT_RD] = 1'b1;
            else                    grant[GNT_WR] = 1'b1;
`else
            grant[GNT_WR] = 1'b1;
`endif
        end else if (wr_req) begin
            grant[GNT_WR] = 1'b1;
        end else if (rd_req) begin
            grant[GNT_RD] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants one of the refresh/write/read engines at a time and
// muxes the owner's command bus onto the SDRAM pins. The pin mux is
// combinational on the registered state so it lines up with the engines'
// own cycle counters. Optional macro: SDRAM_ARBIT_FAIRNESS_EN (alternate
// write/read on ties).
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int BA_W   = SDRAM_BA_W,
    parameter int DQ_W   = SDRAM_DQ_W
) (
    input  logic              sysclk_100M,
    input  logic              rst,
    sdram_arbiter_if.slave    bus
);

    arb_state_e state_q, state_d;
    logic [2:0] ack_q, ack_d;
    logic [2:0] grant;

`ifdef SDRAM_ARBIT_FAIRNESS_EN
    logic       last_rw_q, last_rw_d;

    sdram_arbit_grant u_grant (
        .refresh_req (bus.refresh_req),
        .wr_req      (bus.wr_req),
        .rd_req      (bus.rd_req),
        .last_rw     (last_rw_q),
        .grant       (grant)
    );
`else
    sdram_arbit_grant u_grant (
        .refresh_req (bus.refresh_req),
        .wr_req      (bus.wr_req),
        .rd_req      (bus.rd_req),
        .grant       (grant)
    );
`endif

    // Next state / ack; an engine's end is ignored while its ack is still high
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
`ifdef SDRAM_ARBIT_FAIRNESS_EN
        last_rw_d = last_rw_q;
`endif
        case (state_q)
            ST_INIT: begin
                if (bus.init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (grant[GNT_REF]) begin
                    state_d        = ST_REFRESH;
                    ack_d[GNT_REF] = 1'b1;
                end else if (grant[GNT_WR]) begin
                    state_d       = ST_WRITE;
                    ack_d[GNT_WR] = 1'b1;
`ifdef SDRAM_ARBIT_FAIRNESS_EN
                    last_rw_d     = LAST_WR;
`endif
                end else if (grant[GNT_RD]) begin
                    state_d       = ST_READ;
                    ack_d[GNT_RD] = 1'b1;
`ifdef SDRAM_ARBIT_FAIRNESS_EN
                    last_rw_d     = LAST_RD;
`endif
                end
            end
            ST_REFRESH: begin
                if (bus.refresh_end && !ack_q[GNT_REF]) state_d = ST_ARBIT;
            end
            ST_WRITE: begin
                if (bus.wr_end && !ack_q[GNT_WR]) state_d = ST_ARBIT;
            end
            ST_READ: begin
                if (bus.rd_end && !ack_q[GNT_RD]) state_d = ST_ARBIT;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State, ack and fairness registers with synchronous reset
    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            state_q <= ST_INIT;
            ack_q   <= '0;
`ifdef SDRAM_ARBIT_FAIRNESS_EN
            last_rw_q <= LAST_RD;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
`ifdef SDRAM_ARBIT_FAIRNESS_EN
            last_rw_q <= last_rw_d;
`endif
        end
    end

    logic [3:0]        cmd_mux;
    logic [BA_W-1:0]   ba_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DQ_W-1:0]   dq_mux;
    logic              oe_mux;

    // Pin mux: owner's bus, NOP with zero address while arbitrating
    always_comb begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '0;
        addr_mux = '0;
        dq_mux   = '0;
        oe_mux   = 1'b0;
        case (state_q)
            ST_INIT: begin
                cmd_mux  = bus.init_cmd;
                ba_mux   = bus.init_ba;
                addr_mux = bus.init_addr;
            end
            ST_REFRESH: begin
                cmd_mux  = bus.refresh_cmd;
            end
            ST_WRITE: begin
                cmd_mux  = bus.wr_cmd;
                ba_mux   = bus.wr_ba;
                addr_mux = bus.wr_addr;
                dq_mux   = bus.wr_dq;
                oe_mux   = bus.wr_dq_oe;
            end
            ST_READ: begin
                cmd_mux  = bus.rd_cmd;
                ba_mux   = bus.rd_ba;
                addr_mux = bus.rd_addr;
            end
            default: ;
        endcase
    end

    assign bus.refresh_ack  = ack_q[GNT_REF];
    assign bus.wr_ack       = ack_q[GNT_WR];
    assign bus.rd_ack       = ack_q[GNT_RD];
    assign bus.sdram_cmd    = cmd_mux;
    assign bus.sdram_ba     = ba_mux;
    assign bus.sdram_addr   = addr_mux;
    assign bus.sdram_dq_out = dq_mux;
    assign bus.sdram_dq_oe  = oe_mux;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level owner/age model.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int AW = 13;
    localparam int BW = 2;
    localparam int DW = 16;
`ifdef SDRAM_ARBIT_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    // owner codes used by the model and the grant log
    localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(AW), .BA_W(BW), .DQ_W(DW)) bus ();

    sdram_arbiter #(.ADDR_W(AW), .BA_W(BW), .DQ_W(DW)) dut (
        .sysclk_100M (clk),
        .rst         (rst),
        .bus         (bus)
    );

    int errors = 0;
    int checks = 0;
    int own = O_INIT;
    int age = 0;
    bit last_wr = 1'b0;
    bit drop_on_ack = 1'b1;
    int grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_bus();
        logic [31:0] r;
        r = $urandom; bus.init_cmd = r[3:0]; bus.init_ba = r[5:4]; bus.init_addr = r[18:6];
        r = $urandom; bus.refresh_cmd = r[3:0]; bus.wr_cmd = r[7:4]; bus.rd_cmd = r[11:8];
        bus.wr_ba = r[13:12]; bus.rd_ba = r[15:14]; bus.wr_dq = r[31:16];
        r = $urandom; bus.wr_addr = r[12:0]; bus.rd_addr = r[25:13]; bus.wr_dq_oe = r[26];
    endtask

    // One clock: check outputs against the model, then advance the model
    task automatic step();
        logic [3:0]    ecmd;
        logic [BW-1:0] eba;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edq;
        logic          eoe;
        bit ea_ref, ea_wr, ea_rd, eend;
        int nown, nage, pick;
        bit nl;
        #2;
        ea_ref = (own == O_REF) && (age == 0);
        ea_wr  = (own == O_WR)  && (age == 0);
        ea_rd  = (own == O_RD)  && (age == 0);
        ecmd = 4'b0111; eba = '0; eaddr = '0; edq = '0; eoe = 1'b0;
        case (own)
            O_INIT: begin ecmd = bus.init_cmd; eba = bus.init_ba; eaddr = bus.init_addr; end
            O_REF:  ecmd = bus.refresh_cmd;
            O_WR:   begin ecmd = bus.wr_cmd; eba = bus.wr_ba; eaddr = bus.wr_addr;
                          edq = bus.wr_dq; eoe = bus.wr_dq_oe; end
            O_RD:   begin ecmd = bus.rd_cmd; eba = bus.rd_ba; eaddr = bus.rd_addr; end
            default: ;
        endcase
        chk("refresh_ack", 32'(bus.refresh_ack), 32'(ea_ref));
        chk("wr_ack", 32'(bus.wr_ack), 32'(ea_wr));
        chk("rd_ack", 32'(bus.rd_ack), 32'(ea_rd));
        chk("one_ack", 32'($countones({bus.refresh_ack, bus.wr_ack, bus.rd_ack}) <= 1), 32'd1);
        chk("sdram_cmd", 32'(bus.sdram_cmd), 32'(ecmd));
        chk("sdram_ba", 32'(bus.sdram_ba), 32'(eba));
        chk("sdram_addr", 32'(bus.sdram_addr), 32'(eaddr));
        chk("sdram_dq_out", 32'(bus.sdram_dq_out), 32'(edq));
        chk("sdram_dq_oe", 32'(bus.sdram_dq_oe), 32'(eoe));
        if (bus.refresh_ack === 1'b1) grants.push_back(O_REF);
        if (bus.wr_ack === 1'b1)      grants.push_back(O_WR);
        if (bus.rd_ack === 1'b1)      grants.push_back(O_RD);

        nown = own; nage = age + 1; nl = last_wr;
        if (rst) begin
            nown = O_INIT; nage = 0; nl = 1'b0;
        end else begin
            case (own)
                O_INIT: if (bus.init_end) nown = O_IDLE;
                O_IDLE: begin
                    pick = 0;
                    if (bus.refresh_req)                 pick = O_REF;
                    else if (bus.wr_req && bus.rd_req)   pick = (FAIR && last_wr) ? O_RD : O_WR;
                    else if (bus.wr_req)                 pick = O_WR;
                    else if (bus.rd_req)                 pick = O_RD;
                    if (pick != 0) begin
                        nown = pick; nage = 0;
                        if (pick != O_REF) nl = (pick == O_WR);
                    end
                end
                default: begin
                    eend = (own == O_REF) ? bus.refresh_end :
                           (own == O_WR)  ? bus.wr_end : bus.rd_end;
                    if (eend && age > 0) nown = O_IDLE;
                end
            endcase
        end
        @(posedge clk);
        #1;
        own = nown; age = nage; last_wr = nl;
        if (drop_on_ack) begin
            if (ea_ref) bus.refresh_req = 1'b0;
            if (ea_wr)  bus.wr_req = 1'b0;
            if (ea_rd)  bus.rd_req = 1'b0;
        end
    endtask

    task automatic idle_reqs();
        bus.refresh_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.refresh_end = 1'b0; bus.wr_end = 1'b0; bus.rd_end = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        idle_reqs();
        bus.init_end = 1'b0;
        rand_bus();
        // initial reset, model starts in INIT
        rst = 1'b1;
        @(posedge clk); #1;
        own = O_INIT; age = 0; last_wr = 1'b0;
        step();
        rst = 1'b0;

        // 1: INIT holds, then one cycle after init_end goes to ARBIT
        bus.init_cmd = CMD_PRECHARGE;
        repeat (10) step();
        chk("t1_init_cmd", 32'(bus.sdram_cmd), 32'(CMD_PRECHARGE));
        bus.init_end = 1'b1;
        step();
        bus.init_end = 1'b0;
        chk("t1_nop", 32'(bus.sdram_cmd), 32'h7);
        step();

        // 2: refresh with stale end: no exit in ack cycle, end after 7 cycles
        grants.delete();
        bus.refresh_cmd = CMD_REFRESH;
        bus.refresh_req = 1'b1; bus.refresh_end = 1'b1;
        step();
        step();
        bus.refresh_end = 1'b0;
        chk("t2_in_refresh", 32'(bus.sdram_cmd), 32'(CMD_REFRESH));
        repeat (6) step();
        bus.refresh_end = 1'b1;
        step();
        chk("t2_back_arbit", 32'(bus.sdram_cmd), 32'h7);
        chk("t2_grants", 32'(grants.size()), 32'd1);
        chk("t2_g0", 32'(grants.size() > 0 ? grants[0] : -1), 32'(O_REF));
        idle_reqs();
        step();

        // 3: simultaneous requests served refresh, write, read
        grants.delete();
        bus.refresh_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        bus.refresh_end = 1'b1; bus.wr_end = 1'b1; bus.rd_end = 1'b1;
        repeat (10) step();
        chk("t3_grants", 32'(grants.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("t3_order", 32'(grants.size() > k ? grants[k] : -1), 32'(O_REF + k));
        idle_reqs();
        step();

        // 4: write requested mid-read waits for rd_end and one ARBIT cycle
        grants.delete();
        bus.wr_dq_oe = 1'b1;
        bus.rd_req = 1'b1;
        step(); step();
        bus.wr_req = 1'b1;
        repeat (5) step();
        chk("t4_wr_waits", 32'(grants.size()), 32'd1);
        bus.rd_end = 1'b1;
        step();
        bus.rd_end = 1'b0;
        chk("t4_arbit_gap", 32'(bus.wr_ack), 32'd0);
        step();
        step();
        chk("t4_wr_granted", 32'(grants.size()), 32'd2);
        chk("t4_g1", 32'(grants.size() > 1 ? grants[1] : -1), 32'(O_WR));
        chk("t4_oe_in_write", 32'(bus.sdram_dq_oe), 32'd1);
        bus.wr_end = 1'b1;
        step();
        chk("t4_oe_off", 32'(bus.sdram_dq_oe), 32'd0);
        idle_reqs();
        step();

        // 5: write and read held high over four grants (fresh reset)
        rst = 1'b1; step(); rst = 1'b0;
        bus.init_end = 1'b1; step(); bus.init_end = 1'b0;
        grants.delete();
        drop_on_ack = 1'b0;
        bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.wr_end = 1'b1; bus.rd_end = 1'b1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) step();
        chk("t5_grant_count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk("t5_order", 32'(grants.size() > k ? grants[k] : -1),
                32'((FAIR && (k % 2 == 1)) ? O_RD : O_WR));
        drop_on_ack = 1'b1;
        idle_reqs();
        step();

        // 6: reset during WRITE returns to INIT with acks and dq_oe low
        bus.wr_dq_oe = 1'b1;
        bus.wr_req = 1'b1;
        step(); step(); step();
        chk("t6_in_write", 32'(bus.sdram_dq_oe), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_acks", 32'({bus.refresh_ack, bus.wr_ack, bus.rd_ack}), 32'd0);
        chk("t6_oe", 32'(bus.sdram_dq_oe), 32'd0);
        chk("t6_init_cmd", 32'(bus.sdram_cmd), 32'(bus.init_cmd));
        idle_reqs();
        step();

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            rst = (r[5:0] == 6'd0);
            bus.init_end = (r[7:6] == 2'd0);
            if (r[10:8] == 3'd0)  bus.refresh_req = 1'b1;
            if (r[12:11] == 2'd0) bus.wr_req = 1'b1;
            if (r[14:13] == 2'd0) bus.rd_req = 1'b1;
            bus.refresh_end = (r[16:15] == 2'd0);
            bus.wr_end      = (r[18:17] == 2'd0);
            bus.rd_end      = (r[20:19] == 2'd0);
            rand_bus();
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
